// File: rtl/ext_mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ext_mem_arbiter_pkg
// Description : Shared definitions for the external memory arbiter: FSM state
//               encodings, default widths and the read-latency ceiling.
// Revision    : 1.0 - initial release
// ============================================================================
package ext_mem_arbiter_pkg;

  // Default geometry of the external memory
  localparam int unsigned c_DW_DEFAULT = 8;
  localparam int unsigned c_AW_DEFAULT = 11;

  // Largest supported read latency; the wait counter is sized to hold it
  localparam int unsigned c_RD_LAT_MAX = 15;
  localparam int unsigned c_CNT_W      = 4;

  // Controller FSM encoding
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage : ext_mem_arbiter_pkg
`default_nettype wire

// File: rtl/ext_mem_arbiter_rr_arb.sv
`default_nettype none
// ============================================================================
// Module      : ext_mem_rr_arb
// Description : Two-way round-robin grant logic. The pointer remembers the
//               last granted port; on a tie the other port wins. The pointer
//               resets to port 1 so port 0 wins the first tie.
// Revision    : 1.0 - initial release
// ============================================================================
module ext_mem_rr_arb
  import ext_mem_arbiter_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_req0,
  input  logic i_req1,
  input  logic i_take,   // a grant is being accepted this cycle
  output logic o_win1    // 1 = port 1 wins, 0 = port 0 wins
);

  logic r_last1;

  // Tie goes to the port that was not granted last; otherwise the lone requester
  always_comb begin
    o_win1 = 1'b0;
    if (i_req0 && i_req1) begin
      o_win1 = ~r_last1;
    end else begin
      o_win1 = i_req1;
    end
  end

  // Remember the most recent winner
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last1 <= 1'b1;
    end else if (i_take) begin
      r_last1 <= o_win1;
    end
  end

endmodule : ext_mem_rr_arb
`default_nettype wire

// File: rtl/ext_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ext_mem_arbiter
// Description : Two-port request arbiter and sequencer for the external
//               memory. Grants one access at a time, issues a single-cycle
//               mem_en, waits out the fixed read latency and returns a
//               one-cycle ack with read data. All outputs are registered.
//               Build option EXT_MEM_ARB_RR_EN selects round-robin
//               arbitration; without it port 0 has fixed priority.
// Revision    : 1.0 - initial release
// ============================================================================
module ext_mem_arbiter
  import ext_mem_arbiter_pkg::*;
#(
  parameter int unsigned DW     = c_DW_DEFAULT,
  parameter int unsigned AW     = c_AW_DEFAULT,
  parameter int unsigned RD_LAT = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          ack0,
  output logic          ack1,
  output logic [DW-1:0] rdata,
  output logic          busy,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam logic [c_CNT_W-1:0] c_RD_LAT = RD_LAT[c_CNT_W-1:0];

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 r_win1;
  logic                 r_we;
  logic [c_CNT_W-1:0]   r_cnt;

  logic                 w_win1;
  logic                 w_win1_nxt;
  logic                 w_we_nxt;
  logic [AW-1:0]        w_addr_nxt;
  logic [DW-1:0]        w_wdata_nxt;
  logic [c_CNT_W-1:0]   w_cnt_nxt;
  logic [DW-1:0]        w_rdata_nxt;
  logic                 w_mem_en_nxt;
  logic                 w_mem_we_nxt;
  logic                 w_ack0_nxt;
  logic                 w_ack1_nxt;
  logic                 w_busy_nxt;

`ifdef EXT_MEM_ARB_RR_EN
  logic w_take;

  // A grant is accepted whenever IDLE sees any request
  assign w_take = (r_state == ST_IDLE) && (req0 || req1);

  ext_mem_rr_arb u_rr_arb (
    .clk    (clk),
    .rst    (rst),
    .i_req0 (req0),
    .i_req1 (req1),
    .i_take (w_take),
    .o_win1 (w_win1)
  );
`else
  // Fixed priority: port 1 is granted only when port 0 is not requesting
  assign w_win1 = ~req0;
`endif

  // Next-state and next-output decode; registered outputs are loaded from here
  always_comb begin
    w_state_nxt = r_state;
    w_win1_nxt  = r_win1;
    w_we_nxt    = r_we;
    w_addr_nxt  = mem_addr;
    w_wdata_nxt = mem_wdata;
    w_cnt_nxt   = r_cnt;
    w_rdata_nxt = rdata;
    case (r_state)
      ST_IDLE: begin
        if (req0 || req1) begin
          // mem_addr/mem_wdata double as the request latch
          w_win1_nxt  = w_win1;
          w_we_nxt    = w_win1 ? we1    : we0;
          w_addr_nxt  = w_win1 ? addr1  : addr0;
          w_wdata_nxt = w_win1 ? wdata1 : wdata0;
          w_state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (r_we) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_cnt_nxt   = c_RD_LAT;
          w_state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        w_cnt_nxt = r_cnt - 1'b1;
        // Counter at 1 marks the cycle the memory presents read data
        if (r_cnt <= {{(c_CNT_W-1){1'b0}}, 1'b1}) begin
          w_rdata_nxt = mem_rdata;
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    w_mem_en_nxt = (w_state_nxt == ST_ISSUE);
    w_mem_we_nxt = w_mem_en_nxt && w_we_nxt;
    w_ack0_nxt   = (w_state_nxt == ST_DONE) && !w_win1_nxt;
    w_ack1_nxt   = (w_state_nxt == ST_DONE) &&  w_win1_nxt;
    w_busy_nxt   = (w_state_nxt != ST_IDLE);
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Latches, wait counter and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_win1    <= 1'b0;
      r_we      <= 1'b0;
      r_cnt     <= '0;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      busy      <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rdata     <= '0;
    end else begin
      r_win1    <= w_win1_nxt;
      r_we      <= w_we_nxt;
      r_cnt     <= w_cnt_nxt;
      ack0      <= w_ack0_nxt;
      ack1      <= w_ack1_nxt;
      busy      <= w_busy_nxt;
      mem_en    <= w_mem_en_nxt;
      mem_we    <= w_mem_we_nxt;
      mem_addr  <= w_addr_nxt;
      mem_wdata <= w_wdata_nxt;
      rdata     <= w_rdata_nxt;
    end
  end

endmodule : ext_mem_arbiter
`default_nettype wire

// File: tb/tb_ext_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ext_mem_arbiter
// Description : Self-checking bench for ext_mem_arbiter. A transaction-level
//               model (grant time, per-access latency, shadow memory) gives
//               the expected outputs every cycle; directed sections pin the
//               model with hand-computed values, then random traffic runs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ext_mem_arbiter;

  localparam int DW     = 8;
  localparam int AW     = 11;
  localparam int RD_LAT = 2;
  localparam int NMEM   = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;
  logic          ack0, ack1, busy, mem_en, mem_we;
  logic [DW-1:0] rdata, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;

  always #5 clk = ~clk;

  ext_mem_arbiter #(.DW(DW), .AW(AW), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata(rdata), .busy(busy),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Power-on memory contents; 0x123 holds 0x3C for the directed read
  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    if (a == 11'h123) return 8'h3C;
    return 8'(a) ^ 8'h96;
  endfunction

  // ---------------- memory stub (fixed read latency) ----------------
  logic [DW-1:0] mem [0:NMEM-1];
  bit            vld [0:NMEM-1];
  int            rd_cnt = 0;
  logic [AW-1:0] rd_a = '0;
  logic [DW-1:0] sel_val;

  always @(posedge clk) begin
    if (mem_en && mem_we) begin
      mem[mem_addr] <= mem_wdata;
      vld[mem_addr] <= 1'b1;
    end
    if (mem_en && !mem_we) begin
      rd_cnt <= RD_LAT;
      rd_a   <= mem_addr;
    end else if (rd_cnt > 0) begin
      rd_cnt <= rd_cnt - 1;
    end
  end

  assign sel_val   = vld[rd_a] ? mem[rd_a] : init_val(rd_a);
  // Data valid only RD_LAT cycles after mem_en; complement otherwise
  assign mem_rdata = (rd_cnt == 1) ? sel_val : ~sel_val;

  // ---------------- behavioural model ----------------
  logic [DW-1:0] shadow [0:NMEM-1];
  bit            m_act, m_port, m_we, m_last;
  int            m_k, m_lat;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rdata;
  bit            e_ack0, e_ack1;
  int            cyc = 0;
  int            n_cmp = 0, n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  // Apply what the DUT samples at the coming edge to the transaction model
  task automatic model_sample();
    bit w;
    if (rst) begin
      m_act   = 1'b0;
      m_last  = 1'b1;
      m_rdata = '0;
      return;
    end
    if (m_act) begin
      if (m_k == m_lat) m_act = 1'b0;   // ack cycle over, next cycle is IDLE
      else m_k++;
    end else if (req0 || req1) begin
`ifdef EXT_MEM_ARB_RR_EN
      w = (req0 && req1) ? !m_last : req1;
`else
      w = (req0 && req1) ? 1'b0 : req1;
`endif
      m_act   = 1'b1;
      m_k     = 1;
      m_port  = w;
      m_last  = w;
      m_we    = w ? we1 : we0;
      m_addr  = w ? addr1 : addr0;
      m_wdata = w ? wdata1 : wdata0;
      m_lat   = m_we ? 2 : RD_LAT + 2;
    end
  endtask

  // Advance one clock and compare every output with the model
  task automatic step();
    bit exp_en;
    model_sample();
    @(posedge clk);
    #1;
    cyc++;
    exp_en = m_act && (m_k == 1);
    e_ack0 = m_act && (m_k == m_lat) && !m_port;
    e_ack1 = m_act && (m_k == m_lat) &&  m_port;
    if ((e_ack0 || e_ack1) && !m_we) m_rdata = shadow[m_addr];
    chk("mem_en", mem_en, exp_en);
    chk("mem_we", mem_we, exp_en && m_we);
    chk("busy",   busy,   m_act);
    chk("ack0",   ack0,   e_ack0);
    chk("ack1",   ack1,   e_ack1);
    chk("rdata",  rdata,  m_rdata);
    if (exp_en) begin
      chk("mem_addr",  mem_addr,  m_addr);
      chk("mem_wdata", mem_wdata, m_wdata);
      if (m_we) shadow[m_addr] = m_wdata;
    end
  endtask

  task automatic rnd_fields(output logic we, output logic [AW-1:0] a, output logic [DW-1:0] d);
    we = 1'($urandom_range(0, 1));
    a  = ($urandom_range(0, 7) == 0) ? 11'h7FF : AW'($urandom_range(0, 15));
    d  = DW'($urandom);
  endtask

  int ack_port[$];
  int ack_cyc[$];
  int en_cnt;
  bit rr_mode;

  initial begin
`ifdef EXT_MEM_ARB_RR_EN
    rr_mode = 1'b1;
`else
    rr_mode = 1'b0;
`endif
    for (int a = 0; a < NMEM; a++) shadow[a] = init_val(AW'(a));

    // ---- reset held for two cycles ----
    step();
    step();
    chk("rst_busy", busy, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_rdata", rdata, 0);
    rst = 1'b0;
    step();

    // ---- single write, port 0, top address ----
    req0 = 1'b1; we0 = 1'b1; addr0 = 11'h7FF; wdata0 = 8'hA5;
    step();
    chk("wr_en", mem_en, 1);
    chk("wr_we", mem_we, 1);
    chk("wr_addr", mem_addr, 32'h7FF);
    chk("wr_data", mem_wdata, 32'hA5);
    chk("wr_ack1_c1", ack1, 0);
    step();
    chk("wr_ack0", ack0, 1);
    chk("wr_ack1_c2", ack1, 0);
    req0 = 1'b0;
    step();

    // ---- single read, port 1, 0x123 -> 0x3C ----
    req1 = 1'b1; we1 = 1'b0; addr1 = 11'h123;
    en_cnt = 0;
    for (int i = 1; i <= RD_LAT + 2; i++) begin
      step();
      if (mem_en === 1'b1) en_cnt++;
      if (i == RD_LAT + 2) begin
        chk("rd_ack1", ack1, 1);
        chk("rd_data", rdata, 32'h3C);
        req1 = 1'b0;
      end
    end
    chk("rd_en_pulses", en_cnt, 1);
    step();

    // ---- contention: both ports hold reads ----
    rst = 1'b1;
    step();
    rst = 1'b0;
    req0 = 1'b1; we0 = 1'b0; addr0 = 11'h010;
    req1 = 1'b1; we1 = 1'b0; addr1 = 11'h020;
    for (int i = 0; i < 4 * (RD_LAT + 3); i++) begin
      step();
      if (ack0 === 1'b1) begin ack_port.push_back(0); ack_cyc.push_back(cyc); end
      if (ack1 === 1'b1) begin ack_port.push_back(1); ack_cyc.push_back(cyc); end
    end
    chk("cont_ack_count", ack_port.size(), 4);
    for (int i = 0; i < ack_port.size(); i++) begin
      chk("cont_port", ack_port[i], rr_mode ? (i % 2) : 0);
      if (i > 0) chk("cont_spacing", ack_cyc[i] - ack_cyc[i-1], RD_LAT + 3);
    end
    req0 = 1'b0; req1 = 1'b0;
    for (int i = 0; i < RD_LAT + 4; i++) step();

    // ---- reset during WAIT, then a normal write ----
    req0 = 1'b1; we0 = 1'b0; addr0 = 11'h055;
    step();                      // ISSUE
    step();                      // WAIT
    rst = 1'b1; req0 = 1'b0;
    step();
    chk("rstw_busy", busy, 0);
    chk("rstw_ack0", ack0, 0);
    rst = 1'b0;
    for (int i = 0; i < RD_LAT + 2; i++) begin
      step();
      chk("rstw_no_ack", ack0, 0);
    end
    req0 = 1'b1; we0 = 1'b1; addr0 = 11'h0AA; wdata0 = 8'h5C;
    step();
    chk("rstw_wr_en", mem_en, 1);
    step();
    chk("rstw_wr_ack", ack0, 1);
    req0 = 1'b0;
    step();
    chk("rstw_idle", busy, 0);

    // ---- randomized traffic ----
    for (int i = 0; i < 3000; i++) begin
      step();
      if (rst) begin
        rst = 1'b0;
      end else if ($urandom_range(0, 149) == 0) begin
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
      end else begin
        if (e_ack0) begin
          if ($urandom_range(0, 1) == 0) req0 = 1'b0;
          else rnd_fields(we0, addr0, wdata0);
        end else if (!req0) begin
          if ($urandom_range(0, 2) == 0) begin req0 = 1'b1; rnd_fields(we0, addr0, wdata0); end
        end else if (m_act && !m_port) begin
          if ($urandom_range(0, 3) == 0) rnd_fields(we0, addr0, wdata0);
        end
        if (e_ack1) begin
          if ($urandom_range(0, 1) == 0) req1 = 1'b0;
          else rnd_fields(we1, addr1, wdata1);
        end else if (!req1) begin
          if ($urandom_range(0, 2) == 0) begin req1 = 1'b1; rnd_fields(we1, addr1, wdata1); end
        end else if (m_act && m_port) begin
          if ($urandom_range(0, 3) == 0) rnd_fields(we1, addr1, wdata1);
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_ext_mem_arbiter
`default_nettype wire
